// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared fetch widths, reset PC and sequencing constants
package instr_fetch_ctrl_pkg;
  localparam int FETCH_PC_W = 16;
  localparam int FETCH_INSTR_W = 16;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP = 16'd2;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
endpackage

// File: rtl/instr_fetch_ctrl_fifo.sv
// instr_fetch_ctrl_fifo: DEPTH-entry prefetch FIFO; flush beats push and clears after any pop
module instr_fetch_ctrl_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_dout,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  assign o_count = r_count;
  assign o_dout = (r_count != '0) ? r_mem[r_rd] : '0;
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch PC sequencer feeding decode through a prefetch buffer
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W-1:0] r_fetch_pc;
  logic [AW:0] w_count;
  logic w_pop, w_push;
  assign imem_pc = r_fetch_pc;
  assign out_valid = w_count != '0;
  assign w_pop = out_valid & out_ready;
  // A full buffer still accepts a word when the head leaves in the same cycle
  assign w_push = !halt & !redirect_valid & ((w_count != (AW+1)'(DEPTH)) | w_pop);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fetch_pc <= RESET_PC;
    else if (redirect_valid) r_fetch_pc <= redirect_pc & ~PC_W'(1);
    else if (w_push) r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
  end
  instr_fetch_ctrl_fifo #(.DEPTH(DEPTH), .W(PC_W + INSTR_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_flush(redirect_valid),
    .i_din({r_fetch_pc, imem_instr}),
    .o_dout({out_pc, out_instr}),
    .o_count(w_count)
  );
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed and random checks against a queue-based fetch model
module tb_instr_fetch_ctrl;
  logic clk = 0, reset = 1;
  logic [15:0] imem_pc, imem_instr, redirect_pc = 0, out_pc, out_instr;
  logic redirect_valid = 0, halt = 0, out_valid, out_ready = 0;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [15:0] mpc = 0;

  always #5 clk = ~clk;
  assign imem_instr = imem_pc ^ 16'hA5A5;

  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc = 16'h0000;
  endtask

  // Entered just after a negedge; compares current outputs then advances one clock
  task automatic cyc(input logic rv, input logic [15:0] rpc, input logic h, input logic rdy);
    logic pop, push;
    redirect_valid = rv; redirect_pc = rpc; halt = h; out_ready = rdy;
    #1;
    check("m_valid", 32'(out_valid), 32'(q.size() != 0));
    check("m_pc", 32'(out_pc), q.size() != 0 ? 32'(q[0][31:16]) : 32'h0);
    check("m_instr", 32'(out_instr), q.size() != 0 ? 32'(q[0][15:0]) : 32'h0);
    check("m_imem_pc", 32'(imem_pc), 32'(mpc));
    @(posedge clk);
    pop = q.size() != 0 && rdy;
    push = !h && !rv && (q.size() < 2 || pop);
    if (pop) void'(q.pop_front());
    if (rv) begin
      q.delete();
      mpc = {rpc[15:1], 1'b0};
    end else if (push) begin
      q.push_back({mpc, mpc ^ 16'hA5A5});
      mpc = mpc + 16'd2;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  logic [15:0] t1_pc [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
  logic [15:0] t1_in [4] = '{16'hA5A5, 16'hA5A7, 16'hA5A1, 16'hA5A3};

  task automatic test1(input string tag);
    check({tag, "_rst_valid"}, 32'(out_valid), 0);
    check({tag, "_rst_imem"}, 32'(imem_pc), 0);
    check({tag, "_rst_pc"}, 32'(out_pc), 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, 32'(out_valid), 1);
      check({tag, "_pc"}, 32'(out_pc), 32'(t1_pc[i]));
      check({tag, "_instr"}, 32'(out_instr), 32'(t1_in[i]));
      cyc(0, 0, 0, 1);
    end
  endtask

  initial begin
    do_reset();
    test1("t1");

    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    check("t2_imem", 32'(imem_pc), 32'h0004);
    check("t2_hold_pc", 32'(out_pc), 32'h0000);
    for (int i = 0; i < 3; i++) begin
      check("t2_drain", 32'(out_pc), 32'(i * 2));
      cyc(0, 0, 0, 1);
    end

    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 16'h0013, 0, 0);
    check("t3_gap", 32'(out_valid), 0);
    cyc(0, 0, 0, 0);
    check("t3_valid", 32'(out_valid), 1);
    check("t3_pc", 32'(out_pc), 32'h0012);
    check("t3_instr", 32'(out_instr), 32'hA5B7);

    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    check("t4_pop2", 32'(out_pc), 32'h0002);
    cyc(0, 0, 1, 1);
    check("t4_empty", 32'(out_valid), 0);
    cyc(0, 0, 1, 1);
    check("t4_frozen", 32'(imem_pc), 32'h0004);
    cyc(0, 0, 0, 1);
    check("t4_resume", 32'(out_pc), 32'h0004);

    cyc(1, 16'hFFFE, 0, 1);
    check("t5_gap", 32'(out_valid), 0);
    cyc(0, 0, 0, 1);
    check("t5_top", 32'(out_pc), 32'hFFFE);
    cyc(0, 0, 0, 1);
    check("t5_wrap", 32'(out_pc), 32'h0000);
    cyc(1, 16'h0040, 1, 1);
    check("t5_rh_imem", 32'(imem_pc), 32'h0040);
    cyc(0, 0, 0, 1);
    check("t5_rh_pc", 32'(out_pc), 32'h0040);

    cyc(0, 0, 0, 1);
    #3 reset = 1;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_imem", 32'(imem_pc), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    test1("t6");

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(7) == 0, 16'($urandom), $urandom_range(3) == 0, $urandom_range(3) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
